// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// One request in flight; read data returns with rvalid at least a cycle later.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read per PC and holds the
// returned instruction in the IF/ID register; flushes on redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic [31:0]            pc,
  input  logic [31:0]            npc,
  input  logic                   redirect,
  input  logic                   stall,
  if_fetch_unit_if.master        mem,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_instr
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] KILL  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] hold_instr;
  logic [31:0] load_instr;
  logic        out_free, load, hold_wr;

  // Request is decoded from state; masked during reset so nothing is issued.
  assign mem.imem_req  = (state == FETCH) && rstn;
  assign mem.imem_addr = pc;

  always_comb begin
    out_free   = !if_valid || !stall;
    load       = 1'b0;
    hold_wr    = 1'b0;
    load_instr = hold_instr;
    state_nxt  = state;
    if (redirect) begin
      // A request already issued to the old PC must have its response discarded.
      case (state)
        FETCH:   state_nxt = KILL;
        WAIT:    state_nxt = mem.imem_rvalid ? FETCH : KILL;
        HOLD:    state_nxt = FETCH;
        default: state_nxt = mem.imem_rvalid ? FETCH : KILL;
      endcase
    end else begin
      case (state)
        FETCH: state_nxt = WAIT;
        WAIT: if (mem.imem_rvalid) begin
          if (out_free) begin
            load       = 1'b1;
            load_instr = mem.imem_rdata;
            state_nxt  = FETCH;
          end else begin
            hold_wr   = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: if (out_free) begin
          load      = 1'b1;
          state_nxt = FETCH;
        end
        default: if (mem.imem_rvalid) state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_instr   <= NOP_INSTR;
      hold_instr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (hold_wr) hold_instr <= mem.imem_rdata;
      if (redirect) begin
        pc       <= npc;
        if_valid <= 1'b0;
      end else if (load) begin
        pc       <= npc;
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= load_instr;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable imem model.
module tb_if_fetch_unit;
  localparam logic [31:0] TAG = 32'hDEAD_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc, npc, tgt;
  logic        redirect, stall;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  int          n_vec = 0;
  int          n_err = 0;
  int          mem_lat;

  if_fetch_unit_if bus();

  if_fetch_unit dut (
    .clk(clk), .rstn(rstn), .pc(pc), .npc(npc), .redirect(redirect), .stall(stall),
    .mem(bus.master), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  // Next-PC logic stand-in: sequential unless a redirect target is presented.
  assign npc = redirect ? tgt : pc + 32'd4;

  logic        busy;
  int          cnt;
  logic [31:0] maddr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0; cnt <= 0; maddr <= '0;
      bus.imem_rvalid <= 1'b0; bus.imem_rdata <= '0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      if (bus.imem_req) begin
        if (mem_lat <= 1) begin
          bus.imem_rvalid <= 1'b1; bus.imem_rdata <= bus.imem_addr ^ TAG;
        end else begin
          busy <= 1'b1; cnt <= mem_lat - 1; maddr <= bus.imem_addr;
        end
      end else if (busy) begin
        if (cnt == 1) begin
          bus.imem_rvalid <= 1'b1; bus.imem_rdata <= maddr ^ TAG; busy <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0;
    cyc; cyc;
    rstn = 1'b1; #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; tgt = '0; mem_lat = 1;
    cyc; cyc;
    n_vec++;
    if ({bus.imem_req, pc, if_valid, if_pc, if_instr} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP}) begin
      n_err++; $display("FAIL reset: req=%b pc=%h v=%b if_pc=%h instr=%h want 0 0 0 0 %h",
                        bus.imem_req, pc, if_valid, if_pc, if_instr, NOP);
    end
  endtask

  task automatic test_stream;
    mem_lat = 1; do_reset;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'(4*k)}) begin
        n_err++; $display("FAIL stream_req%0d: req=%b addr=%h want 1 %h", k, bus.imem_req, bus.imem_addr, 32'(4*k));
      end
      if (k > 0) begin
        n_vec++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4*(k-1)), 32'(4*(k-1)) ^ TAG}) begin
          n_err++; $display("FAIL stream_out%0d: v=%b pc=%h instr=%h", k, if_valid, if_pc, if_instr);
        end
      end
      cyc;
      n_vec++;
      if ({bus.imem_req, if_valid} !== 2'b00) begin
        n_err++; $display("FAIL stream_wait%0d: req=%b v=%b want 0 0", k, bus.imem_req, if_valid);
      end
      cyc;
    end
    n_vec++;
    if ({if_valid, if_pc, if_instr, pc} !== {1'b1, 32'h8, 32'h8 ^ TAG, 32'hC}) begin
      n_err++; $display("FAIL stream_last: v=%b if_pc=%h instr=%h pc=%h want 1 8 %h c", if_valid, if_pc, if_instr, pc, 32'h8 ^ TAG);
    end
  endtask

  task automatic test_stall;
    mem_lat = 1; do_reset;
    cyc; cyc;
    stall = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      cyc;
      n_vec++;
      if ({bus.imem_req, if_valid, if_instr, pc} !== {1'b0, 1'b1, TAG, 32'h4}) begin
        n_err++; $display("FAIL stall_hold_c%0d: req=%b v=%b instr=%h pc=%h want 0 1 %h 4", c, bus.imem_req, if_valid, if_instr, pc, TAG);
      end
    end
    cyc;
    n_vec++;
    if ({bus.imem_req, if_instr} !== {1'b0, TAG}) begin
      n_err++; $display("FAIL stall_c7: req=%b instr=%h want 0 %h", bus.imem_req, if_instr, TAG);
    end
    stall = 1'b0;
    cyc;
    n_vec++;
    if ({if_valid, if_pc, if_instr, pc, bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4, 32'h4 ^ TAG, 32'h8, 1'b1, 32'h8}) begin
      n_err++; $display("FAIL stall_release: v=%b if_pc=%h instr=%h pc=%h req=%b addr=%h", if_valid, if_pc, if_instr, pc, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_wait;
    mem_lat = 3; do_reset;
    cyc;
    redirect = 1'b1; tgt = 32'h100;
    cyc;
    redirect = 1'b0;
    n_vec++;
    if ({bus.imem_req, if_valid, pc} !== {1'b0, 1'b0, 32'h100}) begin
      n_err++; $display("FAIL rdw_kill: req=%b v=%b pc=%h want 0 0 100", bus.imem_req, if_valid, pc);
    end
    cyc;
    n_vec++;
    if ({bus.imem_req, if_valid} !== 2'b00) begin
      n_err++; $display("FAIL rdw_stale: req=%b v=%b want 0 0", bus.imem_req, if_valid);
    end
    cyc;
    n_vec++;
    if ({bus.imem_req, bus.imem_addr, if_valid, if_instr} !== {1'b1, 32'h100, 1'b0, NOP}) begin
      n_err++; $display("FAIL rdw_target: req=%b addr=%h v=%b instr=%h want 1 100 0 %h", bus.imem_req, bus.imem_addr, if_valid, if_instr, NOP);
    end
    cyc; cyc; cyc; cyc;
    n_vec++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, 32'h100 ^ TAG}) begin
      n_err++; $display("FAIL rdw_lat3: v=%b if_pc=%h instr=%h want 1 100 %h", if_valid, if_pc, if_instr, 32'h100 ^ TAG);
    end
  endtask

  task automatic test_redirect_rvalid;
    mem_lat = 1; do_reset;
    cyc;
    redirect = 1'b1; tgt = 32'h40;
    cyc;
    redirect = 1'b0;
    n_vec++;
    if ({bus.imem_req, bus.imem_addr, if_valid, if_instr} !== {1'b1, 32'h40, 1'b0, NOP}) begin
      n_err++; $display("FAIL rdr_drop: req=%b addr=%h v=%b instr=%h want 1 40 0 %h", bus.imem_req, bus.imem_addr, if_valid, if_instr, NOP);
    end
    cyc; cyc;
    n_vec++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, 32'h40 ^ TAG}) begin
      n_err++; $display("FAIL rdr_target: v=%b if_pc=%h instr=%h", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_double_redirect;
    mem_lat = 5; do_reset;
    cyc;
    redirect = 1'b1; tgt = 32'h100;
    cyc;
    n_vec++;
    if (bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL dr_c2: req=%b want 0", bus.imem_req);
    end
    tgt = 32'h200;
    cyc;
    n_vec++;
    if ({bus.imem_req, pc} !== {1'b0, 32'h200}) begin
      n_err++; $display("FAIL dr_c3: req=%b pc=%h want 0 200", bus.imem_req, pc);
    end
    tgt = 32'h300;
    cyc;
    redirect = 1'b0;
    n_vec++;
    if ({bus.imem_req, pc} !== {1'b0, 32'h300}) begin
      n_err++; $display("FAIL dr_c4: req=%b pc=%h want 0 300", bus.imem_req, pc);
    end
    cyc;
    n_vec++;
    if (bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL dr_c5: req=%b want 0", bus.imem_req);
    end
    cyc;
    n_vec++;
    if ({bus.imem_req, bus.imem_addr, if_valid, if_instr} !== {1'b1, 32'h300, 1'b0, NOP}) begin
      n_err++; $display("FAIL dr_target: req=%b addr=%h v=%b instr=%h want 1 300 0 %h", bus.imem_req, bus.imem_addr, if_valid, if_instr, NOP);
    end
  endtask

  task automatic test_reset_mid;
    mem_lat = 1; do_reset;
    cyc; cyc;
    stall = 1'b1;
    cyc;
    n_vec++;
    if ({if_valid, pc} !== {1'b1, 32'h4}) begin
      n_err++; $display("FAIL rm_pre: v=%b pc=%h want 1 4", if_valid, pc);
    end
    rstn = 1'b0; #1;
    n_vec++;
    if ({bus.imem_req, pc, if_valid, if_pc, if_instr} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP}) begin
      n_err++; $display("FAIL rm_async: req=%b pc=%h v=%b if_pc=%h instr=%h", bus.imem_req, pc, if_valid, if_pc, if_instr);
    end
    cyc;
    stall = 1'b0; rstn = 1'b1; #1;
    n_vec++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL rm_restart: req=%b addr=%h want 1 0", bus.imem_req, bus.imem_addr);
    end
    cyc; cyc;
    n_vec++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, TAG}) begin
      n_err++; $display("FAIL rm_first: v=%b if_pc=%h instr=%h want 1 0 %h", if_valid, if_pc, if_instr, TAG);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect_wait;
    test_redirect_rvalid;
    test_double_redirect;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
